// File: rtl/router_ctrl_fsm.sv
// Controller FSM for the 1x3 router: decodes the header address and sequences
// the register stage through one-hot Moore state strobes.
module router_ctrl_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [1:0] addr_sel
);

  // One-hot so every strobe is a bare state-register bit.
  localparam logic [7:0] DECODE_ADDRESS     = 8'b0000_0001;
  localparam logic [7:0] LOAD_FIRST_DATA    = 8'b0000_0010;
  localparam logic [7:0] LOAD_DATA          = 8'b0000_0100;
  localparam logic [7:0] FIFO_FULL_STATE    = 8'b0000_1000;
  localparam logic [7:0] LOAD_AFTER_FULL    = 8'b0001_0000;
  localparam logic [7:0] LOAD_PARITY        = 8'b0010_0000;
  localparam logic [7:0] CHECK_PARITY_ERROR = 8'b0100_0000;
  localparam logic [7:0] WAIT_TILL_EMPTY    = 8'b1000_0000;

  logic [7:0] r_state;
  logic [7:0] w_next_state;
  logic [1:0] r_addr_sel;
  logic [1:0] w_emp_sel;
  logic       w_emp;
  logic       w_srst;
  logic       w_hdr_ok;

  assign w_hdr_ok  = pkt_valid && (data_in != 2'b11);
  assign w_emp_sel = (r_state == DECODE_ADDRESS) ? data_in : r_addr_sel;

  // Empty flag of the channel being addressed (live header or latched one).
  always_comb begin
    w_emp = 1'b0;
    case (w_emp_sel)
      2'd0:    w_emp = fifo_empty_0;
      2'd1:    w_emp = fifo_empty_1;
      2'd2:    w_emp = fifo_empty_2;
      default: w_emp = 1'b0;
    endcase
  end

  // Only the latched channel's soft reset can abort a packet.
  always_comb begin
    w_srst = 1'b0;
    case (r_addr_sel)
      2'd0:    w_srst = soft_reset_0;
      2'd1:    w_srst = soft_reset_1;
      2'd2:    w_srst = soft_reset_2;
      default: w_srst = 1'b0;
    endcase
  end

  // Next-state logic; soft reset overrides every normal transition.
  always_comb begin
    w_next_state = DECODE_ADDRESS;
    if (w_srst && (r_state != DECODE_ADDRESS)) begin
      w_next_state = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS:
          if (w_hdr_ok) w_next_state = w_emp ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          else          w_next_state = DECODE_ADDRESS;
        LOAD_FIRST_DATA:
          w_next_state = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       w_next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) w_next_state = LOAD_PARITY;
          else                 w_next_state = LOAD_DATA;
        FIFO_FULL_STATE:
          w_next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        w_next_state = DECODE_ADDRESS;
          else if (low_pkt_valid) w_next_state = LOAD_PARITY;
          else                    w_next_state = LOAD_DATA;
        LOAD_PARITY:
          w_next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          w_next_state = w_emp ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        default:
          w_next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // State and destination-address registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= DECODE_ADDRESS;
      r_addr_sel <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == DECODE_ADDRESS) && w_hdr_ok) r_addr_sel <= data_in;
      else                                         r_addr_sel <= r_addr_sel;
    end
  end

  assign detect_add    = r_state[0];
  assign lfd_state     = r_state[1];
  assign ld_state      = r_state[2];
  assign full_state    = r_state[3];
  assign laf_state     = r_state[4];
  assign rst_int_reg   = r_state[6];
  assign write_enb_reg = r_state[1] | r_state[2] | r_state[4] | r_state[5];
  assign busy          = ~(r_state[0] | r_state[2]);
  assign addr_sel      = r_addr_sel;

endmodule
